matrix_result_drain: RTL and testbench

- Consumer end of the matrix multiplier's output write interface (output_addr / output_data / write_enable).
- Captures the product matrix into internal RAM while the multiplier runs. After the multiplier's done, streams elements out in row-major order (index 0 .. m*n-1) over a valid/ready interface.
- Feeds the next layer or the host readback path.

---
 rtl/matrix_result_drain.sv | 188 ++++++++++++++++++
 tb/tb_matrix_result_drain.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_drain.sv
// Result drain for the matrix multiplier: captures the product matrix
// into a local RAM, then streams it out row-major over valid/ready.
module matrix_result_drain #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [9:0]               m,
  input  logic [9:0]               n,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_en,
  input  logic                     mm_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     drain_done,
  output logic                     addr_err
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN_RD,
    S_DRAIN_WAIT,
    S_PRESENT,
    S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic [19:0]        total_q, total_d;
  logic [19:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_index_q, out_index_d;
  logic               last_q, last_d;
  logic               addr_err_q, addr_err_d;

  logic [DATA_W-1:0]  rd_data_q;
  logic [DATA_W-1:0]  ram [DEPTH];

  logic        start_acc;
  logic [19:0] total_new;
  logic        cfg_err;
  logic        wr_fire;
  logic        wr_in_range;
  logic        wr_ok;
  logic        wr_bad;
  logic        accept;

  // m*n fits in 20 bits since both factors are 10 bits wide.
  assign start_acc   = (state_q == S_IDLE) && start;
  assign total_new   = 20'(m) * 20'(n);
  assign cfg_err     = 32'(total_new) > DEPTH_U;
  assign wr_fire     = (state_q == S_COLLECT) && wr_en;
  assign wr_in_range = (32'(wr_addr) < 32'(total_q)) &&
                       (32'(wr_addr) < DEPTH_U);
  assign wr_ok       = wr_fire && wr_in_range;
  assign wr_bad      = wr_fire && !wr_in_range;
  assign accept      = (state_q == S_PRESENT) && out_ready;

  // Result RAM: write port for capture, registered read port for drain.
  // Not reset, so unwritten entries keep whatever they held before.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ram[wr_addr[RAM_AW-1:0]] <= wr_data;
    end
    if (state_q == S_DRAIN_RD) begin
      rd_data_q <= ram[ptr_q[RAM_AW-1:0]];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (mm_done) begin
          state_d = (total_q != '0) ? S_DRAIN_RD : S_FINISH;
        end
      end
      S_DRAIN_RD: begin
        state_d = S_DRAIN_WAIT;
      end
      S_DRAIN_WAIT: begin
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          state_d = last_q ? S_FINISH : S_DRAIN_RD;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and handshake outputs decoded from the state.
  always_comb begin
    busy       = (state_q != S_IDLE);
    out_valid  = (state_q == S_PRESENT);
    out_last   = (state_q == S_PRESENT) && last_q;
    drain_done = (state_q == S_FINISH);
  end

  // Datapath next-state: config latch, error flag, read pointer, beat regs.
  always_comb begin
    total_d     = total_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    last_d      = last_q;
    addr_err_d  = addr_err_q;

    if (start_acc) begin
      total_d    = total_new;
      ptr_d      = '0;
      last_d     = 1'b0;
      addr_err_d = cfg_err;
    end

    if (wr_bad) begin
      addr_err_d = 1'b1;
    end

    // Beat registers only load here, so they hold while PRESENT stalls.
    if (state_q == S_DRAIN_WAIT) begin
      out_data_d  = rd_data_q;
      out_index_d = ptr_q[ADDR_W-1:0];
      last_d      = (ptr_q == total_q - 20'd1);
    end

    if (accept && !last_q) begin
      ptr_d = ptr_q + 20'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q     <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      last_q      <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      total_q     <= total_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      last_q      <= last_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain: table-driven drain plus
// hand-written stall, error, reset and ignore sequences.
module tb_matrix_result_drain;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [9:0]         m;
  logic [9:0]         n;
  logic [15:0]        wr_addr;
  logic signed [31:0] wr_data;
  logic               wr_en;
  logic               mm_done;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [15:0]        out_index;
  logic               out_last;
  logic               busy;
  logic               drain_done;
  logic               addr_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]        addr;
    logic signed [31:0] data;
    logic               last;
  } vec_t;

  vec_t tbl [6];

  matrix_result_drain dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .m          (m),
    .n          (n),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .mm_done    (mm_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .drain_done (drain_done),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] mm, input logic [9:0] nn);
    m = mm;
    n = nn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic signed [31:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    mm_done = 1'b1;
    @(posedge clk); #1;
    mm_done = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) chk("valid_timeout", out_valid, 1);
  endtask

  task automatic drain_beat(input logic [15:0] idx,
                            input logic signed [31:0] dat,
                            input logic lst);
    wait_valid();
    if (!out_valid) return;
    chk("beat_index", out_index, idx);
    chk("beat_data", out_data, dat);
    chk("beat_last", out_last, lst);
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
  endtask

  initial begin
    int lat;
    int cnt;
    bit sawv;

    tbl[0] = '{16'd0, -32'sd3, 1'b0};
    tbl[1] = '{16'd1, 32'sd7, 1'b0};
    tbl[2] = '{16'd2, 32'sd0, 1'b0};
    tbl[3] = '{16'd3, 32'sd100, 1'b0};
    tbl[4] = '{16'd4, 32'sh80000000, 1'b0};
    tbl[5] = '{16'd5, 32'sh7fffffff, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    m = '0;
    n = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_en = 1'b0;
    mm_done = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", drain_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full 2x3 drain with ready held high.
    do_start(10'd2, 10'd3);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 6; i++) wr(tbl[i].addr, tbl[i].data);
    pulse_done();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("t1_latency", lat, 3);
    for (int i = 0; i < 6; i++) drain_beat(tbl[i].addr, tbl[i].data, tbl[i].last);
    chk("t1_done", drain_done, 1);
    chk("t1_busy_fin", busy, 1);
    @(negedge clk);
    chk("t1_done_pulse", drain_done, 0);
    chk("t1_busy_idle", busy, 0);

    // Same fill, stall 5 cycles on index 2.
    do_start(10'd2, 10'd3);
    for (int i = 0; i < 6; i++) wr(tbl[i].addr, tbl[i].data);
    pulse_done();
    drain_beat(tbl[0].addr, tbl[0].data, tbl[0].last);
    drain_beat(tbl[1].addr, tbl[1].data, tbl[1].last);
    out_ready = 1'b0;
    wait_valid();
    chk("t2_stall_idx", out_index, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_idx", out_index, 2);
      chk("t2_hold_data", out_data, 0);
    end
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) drain_beat(tbl[i].addr, tbl[i].data, tbl[i].last);
    chk("t2_done", drain_done, 1);
    @(negedge clk);

    // Out-of-range write against m*n; index 0 reads stale RAM.
    do_start(10'd1, 10'd2);
    chk("t3_err_start", addr_err, 0);
    wr(16'd1, 32'sd9);
    chk("t3_err_ok", addr_err, 0);
    wr(16'd2, 32'sd55);
    chk("t3_err_set", addr_err, 1);
    pulse_done();
    drain_beat(16'd0, -32'sd3, 1'b0);
    drain_beat(16'd1, 32'sd9, 1'b1);
    @(negedge clk);
    chk("t3_err_sticky", addr_err, 1);

    // Zero-size product: straight to finish.
    do_start(10'd0, 10'd5);
    chk("t4_err_clr", addr_err, 0);
    pulse_done();
    cnt = 0;
    lat = 0;
    sawv = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (out_valid) sawv = 1'b1;
      if (drain_done) begin
        cnt++;
        if (lat == 0) lat = k;
      end
    end
    chk("t4_no_valid", sawv, 0);
    chk("t4_done_cnt", cnt, 1);
    chk("t4_done_lat", (lat >= 1 && lat <= 2), 1);
    chk("t4_idle", busy, 0);

    // Oversized configuration flags at start.
    do_start(10'd40, 10'd40);
    chk("t5_cfg_err", addr_err, 1);
    chk("t5_cfg_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_cfg_rst", addr_err, 0);

    // Reset mid-drain, then a single-element pass.
    do_start(10'd2, 10'd2);
    for (int i = 0; i < 4; i++) wr(16'(i), 32'(10 + i));
    pulse_done();
    drain_beat(16'd0, 32'sd10, 1'b0);
    out_ready = 1'b0;
    wait_valid();
    chk("t6_mid_idx", out_index, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_idx", out_index, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    do_start(10'd1, 10'd1);
    wr(16'd0, 32'sd42);
    pulse_done();
    drain_beat(16'd0, 32'sd42, 1'b1);
    chk("t6_done", drain_done, 1);
    @(negedge clk);

    // Writes outside COLLECT are ignored.
    wr(16'd0, 32'sd5);
    do_start(10'd1, 10'd2);
    wr(16'd0, 32'sd11);
    wr(16'd1, 32'sd22);
    pulse_done();
    wr(16'd1, 32'sd6);
    drain_beat(16'd0, 32'sd11, 1'b0);
    drain_beat(16'd1, 32'sd22, 1'b1);
    @(negedge clk);
    wr(16'd0, 32'sd5);
    do_start(10'd1, 10'd1);
    pulse_done();
    drain_beat(16'd0, 32'sd11, 1'b1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
